lbp_window_encoder: RTL and testbench

LBP_WINDOW_ENCODER -- requirements
Module: lbp_window_encoder

---
 rtl/lbp_window_encoder.sv | 153 +++++++++++++++
 tb/tb_lbp_window_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_window_encoder.sv
// LBP-based hyperdimensional window encoder: per-channel LBP codes bound to channel HVs,
// spatially bundled per sample, temporally bundled per window. Optional macro: ENC_TIEBREAK_EN.
module lbp_window_encoder #(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CHS     = 4,
  parameter int LBP_SIZE    = 6,
  parameter int WINDOW_SIZE = 8,
  parameter int SAMPLE_W    = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [NUM_CHS*SAMPLE_W-1:0]  sample_data,
  output logic [$clog2(NUM_CHS)-1:0]   chan_idx,
  input  logic [DIMENSIONS-1:0]        chan_hv,
  output logic [LBP_SIZE-1:0]          lbp_code,
  input  logic [DIMENSIONS-1:0]        lbp_hv,
  output logic                         window_valid,
  input  logic                         window_ready,
  output logic [DIMENSIONS-1:0]        window_hv
);

  localparam int CIW = $clog2(NUM_CHS);
  localparam int SCW = $clog2(NUM_CHS + 1);
  localparam int TCW = $clog2(WINDOW_SIZE + 1);
  localparam int WUW = $clog2(LBP_SIZE + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ENC, SPAT, OUT} state_t;

  state_t                       state;
  logic [NUM_CHS*SAMPLE_W-1:0]  sample_reg;
  logic signed [SAMPLE_W-1:0]   prev     [NUM_CHS];
  logic [LBP_SIZE-1:0]          lbp      [NUM_CHS];
  logic [SCW-1:0]               spat_cnt [DIMENSIONS];
  logic [TCW-1:0]               temp_cnt [DIMENSIONS];
  logic [WUW-1:0]               warm_cnt;
  logic [TCW-1:0]               win_cnt;
`ifdef ENC_TIEBREAK_EN
  logic [DIMENSIONS-1:0]        tie_hv;
`endif

  logic signed [SAMPLE_W-1:0]   new_s    [NUM_CHS];
  logic [LBP_SIZE-1:0]          lbp_next [NUM_CHS];
  logic [TCW-1:0]               temp_next [DIMENSIONS];
  logic [DIMENSIONS-1:0]        bound;
  logic [DIMENSIONS-1:0]        spat_bit;
  logic [DIMENSIONS-1:0]        win_bits;
  logic [CIW-1:0]               idx_next;
  logic                         last_chan;

  assign sample_ready = (state == IDLE);
  assign last_chan    = (chan_idx == CIW'(NUM_CHS - 1));

  always_comb begin
    bound    = lbp_hv ^ chan_hv;
    idx_next = last_chan ? chan_idx : chan_idx + 1'b1;
    for (int unsigned c = 0; c < NUM_CHS; c++) begin
      new_s[c]    = sample_reg[c*SAMPLE_W +: SAMPLE_W];
      lbp_next[c] = {lbp[c][LBP_SIZE-2:0], (new_s[c] > prev[c])};
    end
    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
      spat_bit[d] = (2 * int'(spat_cnt[d])) > NUM_CHS;
`ifdef ENC_TIEBREAK_EN
      if ((2 * int'(spat_cnt[d])) == NUM_CHS) spat_bit[d] = tie_hv[d];
`endif
      temp_next[d] = temp_cnt[d] + TCW'(spat_bit[d]);
      win_bits[d]  = (2 * int'(temp_next[d])) > WINDOW_SIZE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      sample_reg   <= '0;
      warm_cnt     <= '0;
      win_cnt      <= '0;
      chan_idx     <= '0;
      lbp_code     <= '0;
      window_hv    <= '0;
      window_valid <= 1'b0;
`ifdef ENC_TIEBREAK_EN
      tie_hv       <= '0;
`endif
      for (int unsigned c = 0; c < NUM_CHS; c++) begin
        prev[c] <= '0;
        lbp[c]  <= '0;
      end
      for (int unsigned d = 0; d < DIMENSIONS; d++) begin
        spat_cnt[d] <= '0;
        temp_cnt[d] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (sample_valid) begin
          sample_reg <= sample_data;
          state      <= LOAD;
        end
        LOAD: begin
          for (int unsigned c = 0; c < NUM_CHS; c++) begin
            lbp[c]  <= lbp_next[c];
            prev[c] <= new_s[c];
          end
          if (warm_cnt < WUW'(LBP_SIZE)) begin
            warm_cnt <= warm_cnt + 1'b1;
            state    <= IDLE;
          end else begin
            // Channel 0 must see the freshly shifted code, not the stored one.
            chan_idx <= '0;
            lbp_code <= lbp_next[0];
            state    <= ENC;
          end
        end
        ENC: begin
          for (int unsigned d = 0; d < DIMENSIONS; d++)
            spat_cnt[d] <= spat_cnt[d] + SCW'(bound[d]);
`ifdef ENC_TIEBREAK_EN
          if (chan_idx == '0) tie_hv <= {bound[DIMENSIONS-2:0], bound[DIMENSIONS-1]};
`endif
          if (last_chan) begin
            state <= SPAT;
          end else begin
            chan_idx <= idx_next;
            lbp_code <= lbp[idx_next];
          end
        end
        SPAT: begin
          for (int unsigned d = 0; d < DIMENSIONS; d++) begin
            temp_cnt[d] <= temp_next[d];
            spat_cnt[d] <= '0;
          end
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == TCW'(WINDOW_SIZE - 1)) begin
            window_hv    <= win_bits;
            window_valid <= 1'b1;
            state        <= OUT;
          end else begin
            state <= IDLE;
          end
        end
        OUT: if (window_ready) begin
          window_valid <= 1'b0;
          win_cnt      <= '0;
          for (int unsigned d = 0; d < DIMENSIONS; d++)
            temp_cnt[d] <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_window_encoder.sv
// Scoreboard bench for lbp_window_encoder (NUM_CHS=2, LBP_SIZE=6, WINDOW_SIZE=2, 32-bit HVs).
module tb_lbp_window_encoder;

  localparam int D  = 32;
  localparam int NC = 2;
  localparam int LS = 6;
  localparam int WS = 2;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            sample_valid = 1'b0;
  logic            sample_ready;
  logic [NC*SW-1:0] sample_data = '0;
  logic [0:0]      chan_idx;
  logic [D-1:0]    chan_hv;
  logic [LS-1:0]   lbp_code;
  logic [D-1:0]    lbp_hv;
  logic            window_valid;
  logic            window_ready = 1'b0;
  logic [D-1:0]    window_hv;

  logic [D-1:0] chan_mem [NC];
  logic [D-1:0] lbp_mem  [64];

  assign chan_hv = chan_mem[chan_idx];
  assign lbp_hv  = lbp_mem[lbp_code];

  lbp_window_encoder #(
    .DIMENSIONS(D), .NUM_CHS(NC), .LBP_SIZE(LS), .WINDOW_SIZE(WS), .SAMPLE_W(SW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .chan_idx(chan_idx), .chan_hv(chan_hv), .lbp_code(lbp_code), .lbp_hv(lbp_hv),
    .window_valid(window_valid), .window_ready(window_ready), .window_hv(window_hv)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic signed [SW-1:0] m_prev [NC];
  logic [LS-1:0]        m_lbp  [NC];
  int                   m_warm;
  int                   m_temp [D];
  int                   m_win;
  logic [D-1:0]         exp_q [$];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin m_prev[c] = '0; m_lbp[c] = '0; end
    for (int d = 0; d < D; d++) m_temp[d] = 0;
    m_warm = 0;
    m_win  = 0;
    exp_q.delete();
  endtask

  // Reference: with two channels, a strict majority means both bound bits are set.
  task automatic model_step(input logic [NC*SW-1:0] v, output logic enc);
    logic signed [SW-1:0] s;
    logic [D-1:0] b0, b1, spat, w;
    for (int c = 0; c < NC; c++) begin
      s = v[c*SW +: SW];
      m_lbp[c]  = {m_lbp[c][LS-2:0], (s > m_prev[c])};
      m_prev[c] = s;
    end
    if (m_warm < LS) begin
      m_warm++;
      enc = 1'b0;
      return;
    end
    enc  = 1'b1;
    b0   = lbp_mem[m_lbp[0]] ^ chan_mem[0];
    b1   = lbp_mem[m_lbp[1]] ^ chan_mem[1];
    spat = b0 & b1;
`ifdef ENC_TIEBREAK_EN
    spat = spat | ((b0 ^ b1) & {b0[D-2:0], b0[D-1]});
`endif
    for (int d = 0; d < D; d++) m_temp[d] += int'(spat[d]);
    m_win++;
    if (m_win == WS) begin
      for (int d = 0; d < D; d++) begin
        w[d] = (2 * m_temp[d]) > WS;
        m_temp[d] = 0;
      end
      exp_q.push_back(w);
      m_win = 0;
    end
  endtask

  task automatic drive_sample(input logic [NC*SW-1:0] v, output logic [LS-1:0] code0);
    logic enc;
    int   busy;
    code0 = '0;
    for (int i = 0; i < 50 && !sample_ready; i++) @(negedge clk);
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: sample_ready=%b required 1", sample_ready);
    end
    model_step(v, enc);
    sample_valid = 1'b1;
    sample_data  = v;
    @(negedge clk);
    sample_valid = 1'b0;
    busy = 0;
    while (!sample_ready && !window_valid && busy < 50) begin
      busy++;
      if (enc && busy == 2) begin
        code0 = lbp_code;
        checks++;
        if (chan_idx !== 1'b0 || lbp_code !== m_lbp[0]) begin
          errors++;
          $display("FAIL enc_c0: chan_idx=%0d lbp_code=%b required 0 %b", chan_idx, lbp_code, m_lbp[0]);
        end
      end
      if (enc && busy == 3) begin
        checks++;
        if (chan_idx !== 1'b1 || lbp_code !== m_lbp[1]) begin
          errors++;
          $display("FAIL enc_c1: chan_idx=%0d lbp_code=%b required 1 %b", chan_idx, lbp_code, m_lbp[1]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (busy != (enc ? NC + 2 : 1)) begin
      errors++;
      $display("FAIL busy_cycles: got %0d required %0d", busy, enc ? NC + 2 : 1);
    end
  endtask

  task automatic check_window(input int hold, output logic [D-1:0] obs);
    logic [D-1:0] exp_hv;
    obs = '0;
    for (int i = 0; i < 50 && !window_valid; i++) @(negedge clk);
    checks++;
    if (window_valid !== 1'b1) begin
      errors++;
      $display("FAIL window_valid_wait: window_valid=%b required 1", window_valid);
      return;
    end
    exp_hv = '0;
    if (exp_q.size() > 0) exp_hv = exp_q.pop_front();
    else $display("FAIL window_unexpected: no window queued");
    checks++;
    if (window_hv !== exp_hv) begin
      errors++;
      $display("FAIL window_hv: got %h required %h", window_hv, exp_hv);
    end
    obs = window_hv;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (window_hv !== obs || window_valid !== 1'b1 || sample_ready !== 1'b0) begin
        errors++;
        $display("FAIL window_hold: cyc %0d hv=%h valid=%b ready=%b required %h 1 0",
                 i, window_hv, window_valid, sample_ready, obs);
      end
    end
    window_ready = 1'b1;
    @(negedge clk);
    window_ready = 1'b0;
    checks++;
    if (window_valid !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL window_accept: valid=%b ready=%b required 0 1", window_valid, sample_ready);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (sample_ready !== 1'b1 || window_valid !== 1'b0 || window_hv !== '0 ||
        chan_idx !== 1'b0 || lbp_code !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b hv=%h idx=%0d code=%b required 1 0 0 0 0",
               tag, sample_ready, window_valid, window_hv, chan_idx, lbp_code);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    nrst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_first_window();
    logic [LS-1:0] code0;
    logic [D-1:0]  obs;
    logic [SW-1:0] ch0, ch1;
    for (int i = 0; i < 8; i++) begin
      ch0 = SW'(100 * (i + 1));
      ch1 = SW'($urandom);
      drive_sample({ch1, ch0}, code0);
      if (i == 6) begin
        checks++;
        if (code0 !== 6'b111111) begin
          errors++;
          $display("FAIL rising_code: lbp_code=%b required 111111", code0);
        end
      end
    end
    check_window(0, obs);
  endtask

  task automatic test_second_window_hold();
    logic [LS-1:0] code0;
    logic [D-1:0]  obs;
    for (int i = 0; i < WS; i++) drive_sample(NC*SW'($urandom), code0);
    check_window(20, obs);
  endtask

  task automatic test_tie();
    logic [LS-1:0] code0;
    logic [D-1:0]  obs, exp_tie, b0;
    logic [SW-1:0] val;
    for (int i = 0; i < 8; i++) begin
      val = SW'(100 * i - 1000);
      drive_sample({val, val}, code0);
      if (i % 2 == 1) check_window(0, obs);
    end
    b0 = lbp_mem[63] ^ chan_mem[0];
`ifdef ENC_TIEBREAK_EN
    exp_tie = {b0[D-2:0], b0[D-1]};
`else
    exp_tie = '0;
`endif
    checks++;
    if (obs !== exp_tie) begin
      errors++;
      $display("FAIL tie_window: got %h required %h", obs, exp_tie);
    end
  endtask

  task automatic test_reset_mid_enc();
    logic [LS-1:0] code0;
    logic [D-1:0]  obs;
    sample_valid = 1'b1;
    sample_data  = NC*SW'($urandom);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_enc");
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle_outputs("reset_mid_enc_released");
    for (int i = 0; i < LS + WS; i++) drive_sample(NC*SW'($urandom), code0);
    check_window(0, obs);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) lbp_mem[i] = $urandom;
    chan_mem[0] = $urandom;
    chan_mem[1] = ~chan_mem[0];
    test_reset();
    test_first_window();
    test_second_window_hold();
    test_tie();
    test_reset_mid_enc();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
